// File: rtl/raabb_fp_pkg.sv
// Shared definitions for the Ray-AABB datapath: FloPoCo 11/18 word layout,
// exception codes and the slab_interval_reduce state encoding.
package raabb_fp_pkg;

  // MSB index of a FloPoCo 11/18 word (32 bits total)
  localparam int WIDTH  = 31;
  localparam int EXP_W  = 11;
  localparam int FRAC_W = 18;

  // Field slices
  localparam int EXN_HI   = WIDTH;
  localparam int EXN_LO   = WIDTH - 1;
  localparam int SIGN_BIT = WIDTH - 2;
  localparam int EXP_HI   = WIDTH - 3;
  localparam int EXP_LO   = FRAC_W;
  localparam int FRAC_HI  = FRAC_W - 1;
  localparam int FRAC_LO  = 0;

  // Exception field codes
  localparam logic [1:0] EXN_ZERO   = 2'b00;
  localparam logic [1:0] EXN_NORMAL = 2'b01;
  localparam logic [1:0] EXN_INF    = 2'b10;
  localparam logic [1:0] EXN_NAN    = 2'b11;

  localparam logic [WIDTH:0] FP_ZERO = '0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMP_WAIT = 3'd1,
    ST_UPDATE   = 3'd2,
    ST_FIN_WAIT = 3'd3,
    ST_FIN      = 3'd4,
    ST_OUT      = 3'd5
  } state_t;

  function automatic logic fp_is_nan(input logic [WIDTH:0] v);
    return v[EXN_HI:EXN_LO] == EXN_NAN;
  endfunction

endpackage

// File: rtl/less_than.sv
// FloPoCo 11/18 ordering comparator. less=1 only when a-b would be a normal,
// negative number: equal operands (zero difference) and any inf/NaN
// involvement report "not less". Result is valid CMP_LAT cycles after the
// operands become stable.
module less_than
  import raabb_fp_pkg::*;
#(
  parameter int WIDTH   = raabb_fp_pkg::WIDTH,
  parameter int CMP_LAT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic           less
);

  // Ordering of two finite values; zeros of either sign rank as 0 and any
  // normal (even exponent 0, fraction 0) ranks above zero in magnitude.
  function automatic logic fp_lt(input logic [WIDTH:0] x, input logic [WIDTH:0] y);
    logic [1:0]             ex;
    logic [1:0]             ey;
    logic                   nx;
    logic                   ny;
    logic [EXP_W+FRAC_W:0]  kx;
    logic [EXP_W+FRAC_W:0]  ky;
    logic                   r;
    ex = x[EXN_HI:EXN_LO];
    ey = y[EXN_HI:EXN_LO];
    nx = (ex == EXN_NORMAL) && x[SIGN_BIT];
    ny = (ey == EXN_NORMAL) && y[SIGN_BIT];
    kx = {ex == EXN_NORMAL, x[EXP_HI:FRAC_LO]};
    ky = {ey == EXN_NORMAL, y[EXP_HI:FRAC_LO]};
    if (ex[1] || ey[1]) begin
      r = 1'b0;
    end else if (nx != ny) begin
      r = nx;
    end else if (nx) begin
      r = kx > ky;
    end else begin
      r = kx < ky;
    end
    return r;
  endfunction

  logic               less_d;
  logic [CMP_LAT-1:0] less_pipe_d;
  logic [CMP_LAT-1:0] less_pipe_q;

  // Decision plus shift of the result through the latency pipeline
  always_comb begin
    less_d         = fp_lt(a, b);
    less_pipe_d    = less_pipe_q;
    less_pipe_d[0] = less_d;
    for (int i = 1; i < CMP_LAT; i++) begin
      less_pipe_d[i] = less_pipe_q[i-1];
    end
  end

  // Latency pipeline, cleared by reset so no stale decision survives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) less_pipe_q <= '0;
    else     less_pipe_q <= less_pipe_d;
  end

  assign less = less_pipe_q[CMP_LAT-1];

endmodule

// File: rtl/slab_interval_reduce.sv
// Reduces per-axis slab intervals (t_near, t_far) of one ray to
// t_enter = max(t_near), t_exit = min(t_far) and issues the hit decision.
// Iterative: one axis at a time, every ordering decision from two less_than
// instances. Values are only moved, never modified.
// Optional build macro: RAABB_NAN_MISS_EN (NaN on any accepted input forces a miss).
module slab_interval_reduce
  import raabb_fp_pkg::*;
#(
  parameter int WIDTH   = raabb_fp_pkg::WIDTH,
  parameter int CMP_LAT = 4,
  parameter int NAXES   = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH:0] in_near,
  input  logic [WIDTH:0] in_far,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_hit,
  output logic [WIDTH:0] out_tenter,
  output logic [WIDTH:0] out_texit
);

  localparam int CNT_W  = $clog2(NAXES + 1);
  localparam int WAIT_W = $clog2(CMP_LAT + 1);
  localparam logic [CNT_W-1:0]  NAXES_C    = CNT_W'(NAXES);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(CMP_LAT - 1);

  state_t            state_d,      state_q;
  logic [CNT_W-1:0]  axis_cnt_d,   axis_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d,   wait_cnt_q;
  logic              in_ready_d,   in_ready_q;
  logic              out_valid_d,  out_valid_q;
  logic              out_hit_d,    out_hit_q;
  logic [WIDTH:0]    out_tenter_d, out_tenter_q;
  logic [WIDTH:0]    out_texit_d,  out_texit_q;

  logic [WIDTH:0]    enter_d,      enter_q;
  logic [WIDTH:0]    exit_d,       exit_q;
  logic [WIDTH:0]    cand_near_d,  cand_near_q;
  logic [WIDTH:0]    cand_far_d,   cand_far_q;
  logic [WIDTH:0]    cmpa_x_d,     cmpa_x_q;
  logic [WIDTH:0]    cmpa_y_d,     cmpa_y_q;
  logic [WIDTH:0]    cmpb_x_d,     cmpb_x_q;
  logic [WIDTH:0]    cmpb_y_d,     cmpb_y_q;

  logic              less_a;
  logic              less_b;
  logic              nan_miss;

`ifdef RAABB_NAN_MISS_EN
  logic              nan_seen_d,   nan_seen_q;
  assign nan_miss = nan_seen_q;
`else
  assign nan_miss = 1'b0;
`endif

  // A: accumulator vs candidate near (or final exit vs enter)
  less_than #(.WIDTH(WIDTH), .CMP_LAT(CMP_LAT)) u_cmp_a (
    .clk  (clk),
    .rst  (rst),
    .a    (cmpa_x_q),
    .b    (cmpa_y_q),
    .less (less_a)
  );

  // B: candidate far vs accumulator (or final exit vs zero)
  less_than #(.WIDTH(WIDTH), .CMP_LAT(CMP_LAT)) u_cmp_b (
    .clk  (clk),
    .rst  (rst),
    .a    (cmpb_x_q),
    .b    (cmpb_y_q),
    .less (less_b)
  );

  // Next-state and datapath steering
  always_comb begin
    state_d      = state_q;
    axis_cnt_d   = axis_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    out_valid_d  = out_valid_q;
    out_hit_d    = out_hit_q;
    out_tenter_d = out_tenter_q;
    out_texit_d  = out_texit_q;
    enter_d      = enter_q;
    exit_d       = exit_q;
    cand_near_d  = cand_near_q;
    cand_far_d   = cand_far_q;
    cmpa_x_d     = cmpa_x_q;
    cmpa_y_d     = cmpa_y_q;
    cmpb_x_d     = cmpb_x_q;
    cmpb_y_d     = cmpb_y_q;
`ifdef RAABB_NAN_MISS_EN
    nan_seen_d   = nan_seen_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
`ifdef RAABB_NAN_MISS_EN
          nan_seen_d = nan_seen_q | fp_is_nan(in_near) | fp_is_nan(in_far);
`endif
          if (axis_cnt_q == '0) begin
            enter_d    = in_near;
            exit_d     = in_far;
            axis_cnt_d = CNT_W'(1);
            if (NAXES == 1) begin
              // Single-axis ray: straight to the final decision
              cmpa_x_d   = in_far;
              cmpa_y_d   = in_near;
              cmpb_x_d   = in_far;
              cmpb_y_d   = FP_ZERO;
              wait_cnt_d = '0;
              state_d    = ST_FIN_WAIT;
            end
          end else begin
            cand_near_d = in_near;
            cand_far_d  = in_far;
            cmpa_x_d    = enter_q;
            cmpa_y_d    = in_near;
            cmpb_x_d    = in_far;
            cmpb_y_d    = exit_q;
            wait_cnt_d  = '0;
            state_d     = ST_CMP_WAIT;
          end
        end
      end

      ST_CMP_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = ST_UPDATE;
        else                         wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end

      ST_UPDATE: begin
        if (less_a) enter_d = cand_near_q;
        if (less_b) exit_d  = cand_far_q;
        axis_cnt_d = axis_cnt_q + CNT_W'(1);
        if (axis_cnt_d == NAXES_C) begin
          // Miss if exit < enter or exit < 0
          cmpa_x_d   = exit_d;
          cmpa_y_d   = enter_d;
          cmpb_x_d   = exit_d;
          cmpb_y_d   = FP_ZERO;
          wait_cnt_d = '0;
          state_d    = ST_FIN_WAIT;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      ST_FIN_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = ST_FIN;
        else                         wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end

      ST_FIN: begin
        out_hit_d    = !less_a && !less_b && !nan_miss;
        out_tenter_d = enter_q;
        out_texit_d  = exit_q;
        out_valid_d  = 1'b1;
        state_d      = ST_OUT;
      end

      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          axis_cnt_d  = '0;
`ifdef RAABB_NAN_MISS_EN
          nan_seen_d  = 1'b0;
`endif
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      axis_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_hit_q    <= 1'b0;
      out_tenter_q <= '0;
      out_texit_q  <= '0;
    end else begin
      state_q      <= state_d;
      axis_cnt_q   <= axis_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_hit_q    <= out_hit_d;
      out_tenter_q <= out_tenter_d;
      out_texit_q  <= out_texit_d;
    end
  end

`ifdef RAABB_NAN_MISS_EN
  // Sticky NaN flag for the ray in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) nan_seen_q <= 1'b0;
    else     nan_seen_q <= nan_seen_d;
  end
`endif

  // Interval accumulators and comparator operands; always reloaded before use
  always_ff @(posedge clk) begin
    enter_q     <= enter_d;
    exit_q      <= exit_d;
    cand_near_q <= cand_near_d;
    cand_far_q  <= cand_far_d;
    cmpa_x_q    <= cmpa_x_d;
    cmpa_y_q    <= cmpa_y_d;
    cmpb_x_q    <= cmpb_x_d;
    cmpb_y_q    <= cmpb_y_d;
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_hit    = out_hit_q;
  assign out_tenter = out_tenter_q;
  assign out_texit  = out_texit_q;

endmodule
